// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the register file's single write port between NREQ writeback
//   sources (ALU, load unit, ...). The arbiter grants one source per cycle.
//   The granted write is registered onto RUWr/Rd/DataWr one cycle later.
//   A per-register pending-write scoreboard flags read hazards on the two
//   source operands, so that decode can stall.
//
// Parameters:
//   NREQ  number of writeback requesters (2..8)
//   XLEN  width of writeback data
//   RR    1 = round-robin arbitration, 0 = fixed priority (lowest index wins)
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous, active-high reset
//   req_valid  [NREQ]       requester i has a writeback pending
//   req_rd     [NREQ*5]     destination of requester i, slice [5i+4:5i]
//   req_data   [NREQ*XLEN]  writeback value of requester i
//   req_ready  [NREQ]       one-hot grant, transfer on valid & ready
//   iss_valid  instruction with a destination issued this cycle
//   iss_rd     its destination register
//   chk_rs1    source 1 index being decoded
//   chk_rs2    source 2 index being decoded
//   hazard     a source register has an unretired write
//   RUWr       register file write enable (registered)
//   Rd         register file write index (registered)
//   DataWr     register file write data (registered)
//   pending    scoreboard, bit r = write to x[r] outstanding
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int NREQ = 2,
   parameter int XLEN = 32,
   parameter bit RR   = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*5-1:0]      req_rd,
   input  logic [NREQ*XLEN-1:0]   req_data,
   output logic [NREQ-1:0]        req_ready,
   input  logic                   iss_valid,
   input  logic [4:0]             iss_rd,
   input  logic [4:0]             chk_rs1,
   input  logic [4:0]             chk_rs2,
   output logic                   hazard,
   output logic                   RUWr,
   output logic [4:0]             Rd,
   output logic [XLEN-1:0]        DataWr,
   output logic [31:0]            pending
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   rr_ptr_next;
   logic [NREQ-1:0] grant;
   logic            any_valid;
   logic [4:0]      win_rd;
   logic [XLEN-1:0] win_data;
   logic [31:0]     pending_next;

   // Arbitration: scan the candidates starting at rr_ptr (round-robin) or at
   // index 0 (fixed priority). The first valid requester found is the winner.
   always_comb begin
      int idx;
      // NOTE: every variable gets a default before any conditional
      // assignment. This keeps the block purely combinational, with no latch.
      grant     = '0;
      any_valid = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = RR ? (int'(rr_ptr) + k) % NREQ : k;
         if (!any_valid && req_valid[idx]) begin
            any_valid  = 1'b1;
            win_idx    = PW'(idx);
            grant[idx] = 1'b1;
         end
      end
   end

   assign req_ready = grant;
   assign win_rd    = req_rd[5*int'(win_idx) +: 5];
   assign win_data  = req_data[XLEN*int'(win_idx) +: XLEN];

   // The pointer advances to the slot after the winner. The wrap is explicit
   // because NREQ need not be a power of two.
   assign rr_ptr_next = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PW'(1);

   // Scoreboard update. The clear is applied first and the set second, so a
   // new producer issued on the same edge as a retire to that register
   // keeps the bit set. x0 never shows as pending.
   always_comb begin
      pending_next = pending;
      if (RUWr)
         pending_next[Rd] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0))
         pending_next[iss_rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   // Output stage and arbitration state. A reset drops any in-flight write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every flop samples values from before the edge.
         RUWr    <= 1'b0;
         Rd      <= 5'd0;
         DataWr  <= '0;
         rr_ptr  <= '0;
         pending <= '0;
      end else begin
         pending <= pending_next;
         if (any_valid) begin
            // A write to x0 completes the handshake but is never committed.
            RUWr   <= (win_rd != 5'd0);
            Rd     <= win_rd;
            DataWr <= win_data;
            rr_ptr <= rr_ptr_next;
         end else begin
            RUWr   <= 1'b0;
         end
      end
   end

   // The hazard stays high through the RUWr cycle, because pending clears
   // only on the edge that ends that cycle.
   assign hazard = ((chk_rs1 != 5'd0) && pending[chk_rs1]) ||
                   ((chk_rs2 != 5'd0) && pending[chk_rs2]);

endmodule
